div_acc_seq: RTL and testbench

- Sequencer for the divide accelerator in the Hack-style core.
- Triggered when the core controller matches the software divide loop (StartDiv102 with Divident/Divisor).
- Stalls the pipeline and runs a 16-cycle restoring divider.
- Writes back the exact architectural state the software loop would have produced (M[QUOT_ADDR], M[DIVD_ADDR], D, A), then redirects the PC past the loop.

---
 rtl/div_acc_seq_if.sv | 32 +++
 rtl/div_acc_seq.sv | 153 +++++++++++++++
 tb/tb_div_acc_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_acc_seq_if.sv
// rtl/div_acc_seq_if.sv - core-side bundle for the divide accelerator sequencer
interface div_acc_seq_if;
  logic        StartDiv102;
  logic [15:0] Divident;
  logic [15:0] Divisor;
  logic [15:0] LoopAddr;
  logic [15:0] JgtPc102;
  logic        Flush103;
  logic        Busy;
  logic        Stall;
  logic        AccMemWrEn;
  logic [15:0] AccMemAddr;
  logic [15:0] AccMemData;
  logic        AccDWrEn;
  logic        AccAWrEn;
  logic [15:0] AccRegData;
  logic        AccPcWrEn;
  logic [15:0] AccPc;
  logic        Reject;

  modport master (
    output StartDiv102, Divident, Divisor, LoopAddr, JgtPc102, Flush103,
    input  Busy, Stall, AccMemWrEn, AccMemAddr, AccMemData, AccDWrEn,
           AccAWrEn, AccRegData, AccPcWrEn, AccPc, Reject
  );

  modport slave (
    input  StartDiv102, Divident, Divisor, LoopAddr, JgtPc102, Flush103,
    output Busy, Stall, AccMemWrEn, AccMemAddr, AccMemData, AccDWrEn,
           AccAWrEn, AccRegData, AccPcWrEn, AccPc, Reject
  );
endinterface

// File: rtl/div_acc_seq.sv
// rtl/div_acc_seq.sv - divide accelerator sequencer: stall, 16-cycle restoring divide, loop-exact write-back
module div_acc_seq #(
  parameter logic [15:0] QUOT_ADDR = 16'd1,
  parameter logic [15:0] DIVD_ADDR = 16'd2
) (
  input logic         Clk,
  input logic         Reset,
  div_acc_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_DIV      = 3'd2;
  localparam logic [2:0] S_WB_Q     = 3'd3;
  localparam logic [2:0] S_WB_R     = 3'd4;
  localparam logic [2:0] S_REDIRECT = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] dvs_q, dvs_d;
  logic [15:0] loop_q, loop_d;
  logic [15:0] jpc_q, jpc_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        reject_cond;
  logic [16:0] trial;
  logic [16:0] trial_sub;
  logic        rem_nz;
  logic [15:0] n_val;
  logic [15:0] rem_val;

  assign reject_cond = ($signed(dvs_q) <= 16'sd0) || ($signed(dvd_q) <= 16'sd0) ||
                       ($signed(dvd_q) <= $signed(dvs_q));

  // Shift the next dividend bit (held in the MSB of quo_q) into the partial remainder.
  assign trial     = {rem_q, quo_q[15]};
  assign trial_sub = trial - {1'b0, dvs_q};

  // The software loop overshoots by one iteration when the division is inexact.
  assign rem_nz  = |rem_q;
  assign n_val   = quo_q + {15'd0, rem_nz};
  assign rem_val = rem_nz ? (rem_q - dvs_q) : 16'h0000;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    loop_d  = loop_q;
    jpc_d   = jpc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.StartDiv102 && !bus.Flush103) begin
          dvd_d   = bus.Divident;
          dvs_d   = bus.Divisor;
          loop_d  = bus.LoopAddr;
          jpc_d   = bus.JgtPc102;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (reject_cond) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = 16'd0;
          quo_d   = dvd_q;
          cnt_d   = 5'd0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (!trial_sub[16]) begin
          rem_d = trial_sub[15:0];
          quo_d = {quo_q[14:0], 1'b1};
        end else begin
          rem_d = trial[15:0];
          quo_d = {quo_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = S_WB_Q;
        end
      end
      S_WB_Q:     state_d = S_WB_R;
      S_WB_R:     state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      dvd_q   <= 16'd0;
      dvs_q   <= 16'd0;
      loop_q  <= 16'd0;
      jpc_q   <= 16'd0;
      rem_q   <= 16'd0;
      quo_q   <= 16'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      loop_q  <= loop_d;
      jpc_q   <= jpc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.Busy       = (state_q != S_IDLE);
    bus.Stall      = (state_q != S_IDLE);
    bus.AccMemWrEn = 1'b0;
    bus.AccMemAddr = 16'd0;
    bus.AccMemData = 16'd0;
    bus.AccDWrEn   = 1'b0;
    bus.AccAWrEn   = 1'b0;
    bus.AccRegData = 16'd0;
    bus.AccPcWrEn  = 1'b0;
    bus.AccPc      = 16'd0;
    bus.Reject     = 1'b0;
    case (state_q)
      S_CHECK: bus.Reject = reject_cond;
      S_WB_Q: begin
        bus.AccMemWrEn = 1'b1;
        bus.AccMemAddr = QUOT_ADDR;
        bus.AccMemData = n_val;
      end
      S_WB_R: begin
        bus.AccMemWrEn = 1'b1;
        bus.AccMemAddr = DIVD_ADDR;
        bus.AccMemData = rem_val;
        bus.AccDWrEn   = 1'b1;
        bus.AccRegData = rem_val;
      end
      S_REDIRECT: begin
        bus.AccAWrEn   = 1'b1;
        bus.AccRegData = loop_q;
        bus.AccPcWrEn  = 1'b1;
        bus.AccPc      = jpc_q + 16'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_acc_seq.sv
// tb/tb_div_acc_seq.sv - scoreboard bench for div_acc_seq
module tb_div_acc_seq;
  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  div_acc_seq_if bus ();

  div_acc_seq #(.QUOT_ADDR(16'd1), .DIVD_ADDR(16'd2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          cyc;
    logic        memwr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        dwr;
    logic        awr;
    logic [15:0] regdata;
    logic        pcwr;
    logic [15:0] pc;
    logic        rej;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic mw, input logic [15:0] ad, input logic [15:0] dt,
                      input logic dw, input logic aw, input logic [15:0] rd,
                      input logic pw, input logic [15:0] pc, input logic rj);
    ev_t e;
    e.cyc = c; e.memwr = mw; e.addr = ad; e.data = dt; e.dwr = dw; e.awr = aw;
    e.regdata = rd; e.pcwr = pw; e.pc = pc; e.rej = rj;
    exp_q.push_back(e);
  endtask

  // Every cycle with any write/redirect/reject activity must match the next scoreboard entry.
  always @(negedge Clk) begin
    if (bus.AccMemWrEn || bus.AccDWrEn || bus.AccAWrEn || bus.AccPcWrEn || bus.Reject) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk("ev_memwr", 32'(bus.AccMemWrEn), 32'(e.memwr));
        chk("ev_addr", 32'(bus.AccMemAddr), 32'(e.addr));
        chk("ev_data", 32'(bus.AccMemData), 32'(e.data));
        chk("ev_dwr", 32'(bus.AccDWrEn), 32'(e.dwr));
        chk("ev_awr", 32'(bus.AccAWrEn), 32'(e.awr));
        chk("ev_regdata", 32'(bus.AccRegData), 32'(e.regdata));
        chk("ev_pcwr", 32'(bus.AccPcWrEn), 32'(e.pcwr));
        chk("ev_pc", 32'(bus.AccPc), 32'(e.pc));
        chk("ev_reject", 32'(bus.Reject), 32'(e.rej));
      end
    end
  end

  // Drives a one-cycle start at cycle T (returned); returns at the negedge of T+1.
  task automatic start_div(input logic [15:0] dvd, input logic [15:0] dvs, input logic [15:0] la,
                           input logic [15:0] jpc, input logic flush, input logic expect_it,
                           output int t);
    int q, r;
    logic [15:0] n, rem;
    t = cyc;
    bus.StartDiv102 = 1'b1;
    bus.Divident = dvd; bus.Divisor = dvs; bus.LoopAddr = la; bus.JgtPc102 = jpc;
    bus.Flush103 = flush;
    if (expect_it && !flush) begin
      if ($signed(dvs) <= 0 || $signed(dvd) <= 0 || $signed(dvd) <= $signed(dvs)) begin
        push(t + 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      end else begin
        q = int'(dvd) / int'(dvs);
        r = int'(dvd) % int'(dvs);
        n = 16'(q + (r != 0 ? 1 : 0));
        rem = (r == 0) ? 16'h0000 : 16'(r - int'(dvs));
        push(t + 18, 1, 16'd1, n, 0, 0, 0, 0, 0, 0);
        push(t + 19, 1, 16'd2, rem, 1, 0, rem, 0, 0, 0);
        push(t + 20, 0, 0, 0, 0, 1, la, 1, 16'(jpc + 16'd1), 0);
      end
    end
    @(negedge Clk);
    bus.StartDiv102 = 1'b0;
    bus.Flush103 = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    chk({tag, "_stall"}, 32'(bus.Stall), 32'd0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t;
    Reset = 1'b1;
    bus.StartDiv102 = 1'b0; bus.Flush103 = 1'b0;
    bus.Divident = 0; bus.Divisor = 0; bus.LoopAddr = 0; bus.JgtPc102 = 0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_memwr", 32'(bus.AccMemWrEn), 32'd0);
    chk("rst_pcwr", 32'(bus.AccPcWrEn), 32'd0);
    chk("rst_reject", 32'(bus.Reject), 32'd0);
    chk("rst_regdata", 32'(bus.AccRegData), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // 20000/10: exact; Stall must cover exactly T+1..T+20
    start_div(16'd20000, 16'd10, 16'h0040, 16'h0123, 0, 1, t);
    for (int i = 0; i < 21; i++) begin
      chk("t1_stall", 32'(bus.Stall), 32'((cyc - t) <= 20));
      chk("t1_busy", 32'(bus.Busy), 32'((cyc - t) <= 20));
      @(negedge Clk);
    end
    idle_check("t1_end");

    start_div(16'd7, 16'd2, 16'h0011, 16'hFFFF, 0, 1, t);
    repeat (22) @(negedge Clk);
    idle_check("t2_end");

    start_div(16'd32767, 16'd1, 16'h7000, 16'h0200, 0, 1, t);
    repeat (22) @(negedge Clk);
    idle_check("t3_end");

    start_div(16'd9, 16'd0, 16'd3, 16'd4, 0, 1, t);
    @(negedge Clk);
    idle_check("rej_div0");
    start_div(16'd5, 16'd5, 16'd3, 16'd4, 0, 1, t);
    @(negedge Clk);
    idle_check("rej_equal");
    start_div(16'hFFFD, 16'd2, 16'd3, 16'd4, 0, 1, t);
    @(negedge Clk);
    idle_check("rej_negative");

    // Second start while dividing must be ignored
    start_div(16'd1000, 16'd7, 16'h0055, 16'h0300, 0, 1, t);
    repeat (4) @(negedge Clk);
    bus.StartDiv102 = 1'b1; bus.Divident = 16'd50; bus.Divisor = 16'd3;
    bus.LoopAddr = 16'h0099; bus.JgtPc102 = 16'h0999;
    @(negedge Clk);
    bus.StartDiv102 = 1'b0;
    repeat (17) @(negedge Clk);
    idle_check("t_ignore_end");

    start_div(16'd100, 16'd3, 16'd1, 16'd2, 1, 1, t);
    chk("flush_busy_t1", 32'(bus.Busy), 32'd0);
    @(negedge Clk);
    idle_check("flush_t2");

    // Reset mid-DIV: no write-back, then a clean run
    start_div(16'd20000, 16'd10, 16'h0040, 16'h0123, 0, 0, t);
    while (cyc < t + 10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_memwr", 32'(bus.AccMemWrEn), 32'd0);
    chk("midrst_pcwr", 32'(bus.AccPcWrEn), 32'd0);
    Reset = 1'b0;
    repeat (15) @(negedge Clk);
    idle_check("midrst_quiet");
    start_div(16'd12345, 16'd100, 16'h0021, 16'h0456, 0, 1, t);
    repeat (22) @(negedge Clk);
    idle_check("post_rst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
